// File: rtl/sample_stream_tx.sv
// rtl/sample_stream_tx.sv - per-channel sample request, capture and serial DAC shifter
module sample_stream_tx #(
  parameter int SAMPLE_W     = 16,
  parameter int CLKS_PER_BIT = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_tick,
  input  logic                sample_ready,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                generate_next,
  output logic                dac_sclk,
  output logic                dac_sdata,
  output logic                dac_frame,
  output logic                busy,
  output logic                timeout_err,
  output logic                missed_tick
);

  localparam int CYC_W  = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(SAMPLE_W);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [CYC_W-1:0]  CYC_HALF  = CYC_W'(CLKS_PER_BIT / 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SAMPLE_W - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, SHIFT} state_t;

  state_t              state, state_n;
  logic [SAMPLE_W-1:0] shift_q, shift_n;
  logic [BIT_W-1:0]    bit_q, bit_n;
  logic [CYC_W-1:0]    cyc_q, cyc_n;
  logic [WAIT_W-1:0]   wait_q, wait_n;
  logic                timeout_set;

  always_comb begin
    state_n     = state;
    shift_n     = shift_q;
    bit_n       = bit_q;
    cyc_n       = cyc_q;
    wait_n      = wait_q;
    timeout_set = 1'b0;
    case (state)
      IDLE: begin
        if (sample_tick) state_n = REQ;
      end
      REQ: begin
        state_n = WAIT;
        wait_n  = '0;
      end
      WAIT: begin
        if (sample_ready) begin
          shift_n = sample;
          bit_n   = '0;
          cyc_n   = '0;
          state_n = SHIFT;
        end else if (wait_q == WAIT_LAST) begin
          // generator never answered: emit a silent frame so the DAC keeps its cadence
          shift_n     = '0;
          bit_n       = '0;
          cyc_n       = '0;
          timeout_set = 1'b1;
          state_n     = SHIFT;
        end else begin
          wait_n = wait_q + 1'b1;
        end
      end
      SHIFT: begin
        if (cyc_q == CYC_LAST) begin
          cyc_n = '0;
          if (bit_q == BIT_LAST) begin
            state_n = IDLE;
            shift_n = '0;
            bit_n   = '0;
          end else begin
            bit_n   = bit_q + 1'b1;
            shift_n = {shift_q[SAMPLE_W-2:0], 1'b0};
          end
        end else begin
          cyc_n = cyc_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // outputs are registered from next-state values so they line up with the state they describe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      shift_q       <= '0;
      bit_q         <= '0;
      cyc_q         <= '0;
      wait_q        <= '0;
      generate_next <= 1'b0;
      dac_sclk      <= 1'b0;
      dac_sdata     <= 1'b0;
      dac_frame     <= 1'b0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
      missed_tick   <= 1'b0;
    end else begin
      state         <= state_n;
      shift_q       <= shift_n;
      bit_q         <= bit_n;
      cyc_q         <= cyc_n;
      wait_q        <= wait_n;
      generate_next <= (state_n == REQ);
      busy          <= (state_n != IDLE);
      dac_sdata     <= (state_n == SHIFT) && shift_n[SAMPLE_W-1];
      dac_sclk      <= (state_n == SHIFT) && (cyc_n >= CYC_HALF);
      dac_frame     <= (state_n == SHIFT) && (bit_n == '0);
      timeout_err   <= timeout_err | timeout_set;
      missed_tick   <= missed_tick | (sample_tick && (state != IDLE));
    end
  end

endmodule

// File: tb/tb_sample_stream_tx.sv
// tb/tb_sample_stream_tx.sv - directed scoreboard bench for sample_stream_tx
module tb_sample_stream_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        tick_a, ready_a, tick_b, ready_b;
  logic [15:0] sample_a;
  logic [7:0]  sample_b;
  logic a_gen, a_sclk, a_sdata, a_frame, a_busy, a_to, a_mt;
  logic b_gen, b_sclk, b_sdata, b_frame, b_busy, b_to, b_mt;

  sample_stream_tx dut_a (
    .clk(clk), .reset(reset), .sample_tick(tick_a), .sample_ready(ready_a), .sample(sample_a),
    .generate_next(a_gen), .dac_sclk(a_sclk), .dac_sdata(a_sdata), .dac_frame(a_frame),
    .busy(a_busy), .timeout_err(a_to), .missed_tick(a_mt));

  sample_stream_tx #(.SAMPLE_W(8), .CLKS_PER_BIT(2), .TIMEOUT(15)) dut_b (
    .clk(clk), .reset(reset), .sample_tick(tick_b), .sample_ready(ready_b), .sample(sample_b),
    .generate_next(b_gen), .dac_sclk(b_sclk), .dac_sdata(b_sdata), .dac_frame(b_frame),
    .busy(b_busy), .timeout_err(b_to), .missed_tick(b_mt));

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] sb[$];
  bit          sel = 1'b0;
  int          waited;

  wire o_gen   = sel ? b_gen   : a_gen;
  wire o_sclk  = sel ? b_sclk  : a_sclk;
  wire o_sdata = sel ? b_sdata : a_sdata;
  wire o_frame = sel ? b_frame : a_frame;
  wire o_busy  = sel ? b_busy  : a_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tick(input logic v);
    if (sel) tick_b = v;
    else     tick_a = v;
  endtask

  task automatic frame_check(input int w, input int cpb, input int max_wait,
                             input bit tick_last, output int n_wait);
    logic [15:0] exp;
    n_wait = 0;
    while (o_frame !== 1'b1 && n_wait < max_wait) begin
      step();
      n_wait++;
    end
    chk("frame_start", o_frame, 1);
    exp = '0;
    if (sb.size() == 0) chk("sb_nonempty", 0, 1);
    else exp = sb.pop_front();
    if (o_frame === 1'b1) begin
      for (int c = 0; c < w * cpb; c++) begin
        chk("sdata", o_sdata, exp[w - 1 - c / cpb]);
        chk("sclk",  o_sclk,  ((c % cpb) >= (cpb / 2)));
        chk("frame", o_frame, (c / cpb) == 0);
        chk("busy",  o_busy,  1);
        chk("gen_in_shift", o_gen, 0);
        if (tick_last && c == w * cpb - 1) set_tick(1'b1);
        step();
        set_tick(1'b0);
      end
      chk("end_state", {o_busy, o_sclk, o_sdata, o_frame}, 0);
    end
  endtask

  initial begin
    reset = 1'b0;
    tick_a = 0; ready_a = 0; sample_a = '0;
    tick_b = 0; ready_b = 0; sample_b = '0;
    repeat (3) step();
    chk("reset_a", {a_gen, a_sclk, a_sdata, a_frame, a_busy, a_to, a_mt}, 0);
    chk("reset_b", {b_gen, b_sclk, b_sdata, b_frame, b_busy, b_to, b_mt}, 0);
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      chk("idle_quiet", {a_gen, a_sclk, a_sdata, a_frame, a_busy, a_to, a_mt}, 0);
    end

    // nominal frame: request one cycle after tick, ready in first WAIT cycle
    chk("gen_before_tick", a_gen, 0);
    tick_a = 1; step(); tick_a = 0;
    chk("req_gen", a_gen, 1);
    chk("req_busy", a_busy, 1);
    step();
    ready_a = 1; sample_a = 16'hA5C3; sb.push_back(16'hA5C3);
    chk("wait_gen", a_gen, 0);
    chk("wait_busy", a_busy, 1);
    step();
    ready_a = 0; sample_a = '0;
    frame_check(16, 4, 4, 1'b0, waited);
    chk("nominal_latency", waited, 0);

    // generator silent: 15 WAIT cycles then a zero frame
    tick_a = 1; step(); tick_a = 0;
    chk("to_req_gen", a_gen, 1);
    sb.push_back(16'h0000);
    step();
    chk("to_not_yet", a_to, 0);
    frame_check(16, 4, 40, 1'b0, waited);
    chk("to_wait_len", waited, 15);
    chk("to_set", a_to, 1);
    repeat (20) step();
    chk("to_sticky", a_to, 1);
    chk("mt_clear", a_mt, 0);

    // tick in the final SHIFT cycle is dropped; tick right after busy falls is taken
    tick_a = 1; step(); tick_a = 0;
    step();
    ready_a = 1; sample_a = 16'h3C5A; sb.push_back(16'h3C5A);
    step();
    ready_a = 0;
    frame_check(16, 4, 4, 1'b1, waited);
    chk("last_shift_mt", a_mt, 1);
    chk("last_shift_no_req", a_gen, 0);
    tick_a = 1; step(); tick_a = 0;
    chk("after_idle_req", a_gen, 1);
    step();
    ready_a = 1; sample_a = 16'h8001; sb.push_back(16'h8001);
    step();
    ready_a = 0;
    frame_check(16, 4, 4, 1'b0, waited);
    chk("after_idle_lat", waited, 0);

    reset = 1'b0; step(); reset = 1'b1;
    chk("flags_cleared", {a_to, a_mt}, 0);

    // tick during WAIT
    tick_a = 1; step(); tick_a = 0;
    step();
    tick_a = 1; step(); tick_a = 0;
    chk("wait_tick_mt", a_mt, 1);
    chk("wait_tick_no_req", a_gen, 0);
    ready_a = 1; sample_a = 16'h1234; sb.push_back(16'h1234);
    step();
    ready_a = 0;
    frame_check(16, 4, 4, 1'b0, waited);
    chk("wait_tick_no_extra", a_gen, 0);

    // async reset in bit 7 of a frame
    tick_a = 1; step(); tick_a = 0;
    step();
    ready_a = 1; sample_a = 16'hFFFF; sb.push_back(16'hFFFF);
    step();
    ready_a = 0;
    repeat (7 * 4 + 1) step();
    chk("pre_abort_busy", a_busy, 1);
    void'(sb.pop_front());
    reset = 1'b0;
    #1;
    chk("async_reset", {a_gen, a_sclk, a_sdata, a_frame, a_busy, a_to, a_mt}, 0);
    repeat (5) begin
      step();
      chk("held_reset", {a_sclk, a_busy}, 0);
    end
    reset = 1'b1;
    repeat (10) begin
      step();
      chk("post_reset_quiet", {a_sclk, a_sdata, a_frame, a_busy}, 0);
    end
    tick_a = 1; step(); tick_a = 0;
    step();
    ready_a = 1; sample_a = 16'hC001; sb.push_back(16'hC001);
    step();
    ready_a = 0;
    frame_check(16, 4, 4, 1'b0, waited);
    chk("fresh_latency", waited, 0);

    // 8-bit, 2 clocks per bit instance
    sel = 1'b1;
    tick_b = 1; step(); tick_b = 0;
    chk("b_req_gen", b_gen, 1);
    step();
    ready_b = 1; sample_b = 8'h81; sb.push_back(16'h0081);
    step();
    ready_b = 0;
    frame_check(8, 2, 4, 1'b0, waited);
    chk("b_latency", waited, 0);
    chk("b_flags", {b_to, b_mt}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
